exc_commit: RTL

EXC_COMMIT -- requirements
Module: exc_commit

---
 rtl/exc_commit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/exc_commit.sv
// exc_commit: commit-stage exception/ERET sequencer (flush, CP0 update, fetch redirect).
// Optional macro CP0_VECTORED_INT_EN enables Cause.IV interrupt vectoring (offset 0x200).
//
// exc_type encoding (5 bits):
//   0 NoExc  1 Intr  2 TLBM  3 TLBR fetch/load  4 TLBR store  5 TLBI fetch/load
//   6 TLBI store  7 AdEL  8 AdES  9 IBE  10 DBE  11 SysC  12 Bp  13 RI  14 CpU
//   15 Ov  16 Trap  17 ERET  (18..31 reserved, treated as NoExc)
// Revision: 1.0 initial release
`default_nettype none

module exc_commit #(
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000,
  parameter logic [31:0] BOOT_BASE   = 32'hBFC0_0200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_flag,
  input  logic [4:0]  exc_type,
  input  logic [31:0] exc_baddr,
  input  logic        exc_save,
  input  logic [31:0] pc,
  input  logic        inslot,
  input  logic        status_bev,
  input  logic        cause_iv,
  input  logic        redir_ready,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic        busy,
  output logic        exl,
  output logic [31:0] epc,
  output logic [31:0] badvaddr,
  output logic [4:0]  exccode,
  output logic        bd,
  output logic        ctx_we
);

  localparam logic [4:0] C_INTR   = 5'd1;
  localparam logic [4:0] C_TLBM   = 5'd2;
  localparam logic [4:0] C_TLBR_L = 5'd3;
  localparam logic [4:0] C_TLBR_S = 5'd4;
  localparam logic [4:0] C_TLBI_L = 5'd5;
  localparam logic [4:0] C_TLBI_S = 5'd6;
  localparam logic [4:0] C_ADEL   = 5'd7;
  localparam logic [4:0] C_ADES   = 5'd8;
  localparam logic [4:0] C_ERET   = 5'd17;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLUSH = 2'd1, S_REDIR = 2'd2} state_t;

  state_t      r_state;
  logic        w_valid;
  logic        w_is_eret;
  logic        w_has_baddr;
  logic        w_vec;
  logic [4:0]  w_code;
  logic [31:0] w_base;
  logic [31:0] w_target;

`ifdef CP0_VECTORED_INT_EN
  assign w_vec = cause_iv;
`else
  logic w_unused_iv;
  assign w_unused_iv = cause_iv;
  assign w_vec       = 1'b0;
`endif

  always_comb begin
    w_valid     = (exc_type != 5'd0) && (exc_type <= C_ERET);
    w_is_eret   = (exc_type == C_ERET);
    w_has_baddr = (exc_type >= C_TLBM) && (exc_type <= C_ADES);
    w_base      = status_bev ? BOOT_BASE : EBASE_RESET;
    case (exc_type)
      C_INTR:             w_code = 5'd0;
      C_TLBM:             w_code = 5'd1;
      C_TLBR_L, C_TLBI_L: w_code = 5'd2;
      C_TLBR_S, C_TLBI_S: w_code = 5'd3;
      C_ADEL:             w_code = 5'd4;
      default:            w_code = exc_type - 5'd3;  // ADES..Trap are contiguous 5..13
    endcase
    // Refill vector depends on EXL before this event updates it.
    if (w_is_eret)
      w_target = epc;
    else if ((exc_type == C_TLBR_L || exc_type == C_TLBR_S) && !exl)
      w_target = w_base;
    else if (exc_type == C_INTR && w_vec)
      w_target = w_base + 32'h200;
    else
      w_target = w_base + 32'h180;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      flush       <= 1'b0;
      redir_valid <= 1'b0;
      redir_pc    <= 32'h0;
      busy        <= 1'b0;
      exl         <= 1'b1;
      epc         <= 32'h0;
      badvaddr    <= 32'h0;
      exccode     <= 5'd0;
      bd          <= 1'b0;
      ctx_we      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (exc_flag && w_valid) begin
            r_state  <= S_FLUSH;
            flush    <= 1'b1;
            busy     <= 1'b1;
            ctx_we   <= exc_save;
            redir_pc <= w_target;
            if (w_is_eret) begin
              exl <= 1'b0;
            end else begin
              exl     <= 1'b1;
              exccode <= w_code;
              if (!exl) begin
                epc <= inslot ? pc - 32'd4 : pc;
                bd  <= inslot;
              end
              if (w_has_baddr)
                badvaddr <= exc_baddr;
            end
          end
        end
        S_FLUSH: begin
          flush       <= 1'b0;
          ctx_we      <= 1'b0;
          redir_valid <= 1'b1;
          r_state     <= S_REDIR;
        end
        S_REDIR: begin
          if (redir_ready) begin
            redir_valid <= 1'b0;
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
